register_file: RTL and testbench
================================

Name: register_file

Overview:
- Architectural register file that answers the processor's register-file port group: two asynchronous read ports and one synchronous write port.
- Sits beside the processor core. Decode drives the read addresses; writeback drives write address, value and enable.
- The storage array has no reset. After every reset, and on request, an internal clear sequencer zeroes it one entry per cycle.
- A handshaked debug read port lets the test harness inspect registers without disturbing the pipeline.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 6, address width; matches the processor's 6-bit address ports.
- NUM_REGS, 64, entry count; must equal 2**ADDR_WIDTH.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- register_file_read_address_1  input  ADDR_WIDTH  read port 1 address.
- register_file_read_address_2  input  ADDR_WIDTH  read port 2 address.
- register_file_read_value_1  output  DATA_WIDTH  read port 1 data, combinational.
- register_file_read_value_2  output  DATA_WIDTH  read port 2 data, combinational.
- register_file_write_address  input  ADDR_WIDTH  write address.
- register_file_write_value  input  DATA_WIDTH  write data.
- register_file_write_enable  input  1  write strobe, sampled on clock edge.
- clear_request  input  1  single-cycle pulse; restarts the clear sequence.
- ready  output  1  high when the array is valid and writes are accepted.
- write_dropped  output  1  sticky flag: a write arrived while not ready.
- debug_request  input  1  debug read request.
- debug_address  input  ADDR_WIDTH  debug read address.
- debug_acknowledge  output  1  one-cycle pulse; debug_data is valid.
- debug_data  output  DATA_WIDTH  registered debug read result.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=CLEAR, clear index=0
  - ready=0, write_dropped=0
  - debug_acknowledge=0, debug_data=0
  - array contents are not reset.
- State CLEAR:
  - Each edge writes 0 to array[index], then index increments.
  - When index==NUM_REGS-1 is written, the next state is READY and ready=1 on that edge.
  - Clear takes exactly NUM_REGS cycles after reset release.
- While CLEAR:
  - Both read ports return 0.
  - Processor writes are discarded; each one sets write_dropped, which stays set until reset.
  - clear_request is ignored.
  - debug_request is held off: no acknowledge until READY.
- State READY:
  - On register_file_write_enable=1 and address!=0, array[address] <= value on the edge.
  - Writes to address 0 are discarded silently; they do not set write_dropped.
  - clear_request=1 on an edge moves to CLEAR with index=0 and drops ready on that edge. A write on the same edge is discarded and flagged.
- Reads:
  - Address 0 always returns 0.
  - Other addresses return array contents combinationally, with zero clock latency. The processor samples them on the next edge.
- Debug port:
  - In READY, debug_request=1 with debug_acknowledge=0 on an edge captures the read of debug_address into debug_data, with the same semantics as the read ports (including bypass when enabled). debug_acknowledge=1 for exactly one cycle.
  - A request held high is accepted at most every other cycle.
  - Entering CLEAR does not cancel an acknowledge already issued.
- Reset mid-clear restarts at index 0. Reset mid-debug clears debug_acknowledge.

Optional Feature:
- Macro REGISTER_FILE_BYPASS_EN.
- Defined: if a write is enabled, accepted (READY, address!=0) and its address equals a read or debug address in the same cycle, that port returns register_file_write_value combinationally (write-through). The processor needs this because writeback and decode overlap.
- Undefined: read ports return the pre-write array value; the new value is visible from the next cycle.

Decomposition:
- Package register_file_pkg holds:
  - state enum {CLEAR, READY}
  - default DATA_WIDTH, ADDR_WIDTH, NUM_REGS constants
  - ZERO_REGISTER address constant (0).
- One sub-module is natural: register_file_clear_sequencer. It owns state, index, ready and the write_dropped logic, and drives the array write mux. Array, read muxes and bypass stay in the top level.

Test Plan:
- Reset release -> ready=0 for exactly 64 cycles, then ready=1. Read of address 5 returns 0 throughout; debug read of address 63 after ready returns 0.
- READY, write address 7 value 0x12345678 -> the following cycle read_address_1=7 returns 0x12345678. Write address 0 value 0xFFFFFFFF -> address 0 reads 0, write_dropped stays 0.
- Same-cycle write of address 3 = 0xA5A5A5A5 with read_address_2=3 -> value 0xA5A5A5A5 with REGISTER_FILE_BYPASS_EN; old value 0 without it.
- Write during clear, 10 cycles after reset -> write is discarded and write_dropped=1. After ready, address still reads 0.
- clear_request pulse after loading address 9 = 0xDEAD -> ready drops next edge, returns after 64 cycles, and address 9 reads 0.
- debug_request held high with debug_address=9 holding 0xBEEF -> debug_acknowledge pulses every other cycle with debug_data=0xBEEF. Reset asserted mid-clear -> ready stays 0 for a full 64 cycles after release.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared types and default sizing for the register file.
package register_file_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 6;
  localparam int DEFAULT_NUM_REGS   = 64;

  // Architectural zero register: always reads 0, writes are ignored.
  localparam int ZERO_REGISTER = 0;

endpackage

// File: rtl/register_file_if.sv
// Register-file port group: two read ports, one write port, clear control,
// status, and the handshaked debug read port.
interface register_file_if
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] register_file_read_address_1;
  logic [ADDR_WIDTH-1:0] register_file_read_address_2;
  logic [DATA_WIDTH-1:0] register_file_read_value_1;
  logic [DATA_WIDTH-1:0] register_file_read_value_2;
  logic [ADDR_WIDTH-1:0] register_file_write_address;
  logic [DATA_WIDTH-1:0] register_file_write_value;
  logic                  register_file_write_enable;
  logic                  clear_request;
  logic                  ready;
  logic                  write_dropped;
  logic                  debug_request;
  logic [ADDR_WIDTH-1:0] debug_address;
  logic                  debug_acknowledge;
  logic [DATA_WIDTH-1:0] debug_data;

  modport master (
    output register_file_read_address_1,
    output register_file_read_address_2,
    input  register_file_read_value_1,
    input  register_file_read_value_2,
    output register_file_write_address,
    output register_file_write_value,
    output register_file_write_enable,
    output clear_request,
    input  ready,
    input  write_dropped,
    output debug_request,
    output debug_address,
    input  debug_acknowledge,
    input  debug_data
  );

  modport slave (
    input  register_file_read_address_1,
    input  register_file_read_address_2,
    output register_file_read_value_1,
    output register_file_read_value_2,
    input  register_file_write_address,
    input  register_file_write_value,
    input  register_file_write_enable,
    input  clear_request,
    output ready,
    output write_dropped,
    input  debug_request,
    input  debug_address,
    output debug_acknowledge,
    output debug_data
  );

endinterface

// File: rtl/register_file_clear_sequencer.sv
// CLEAR/READY control: zeroes the array one entry per cycle after reset or a
// clear request, gates processor writes and keeps the sticky write_dropped flag.
module register_file_clear_sequencer
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_value,
  input  logic                  clear_request,
  output logic                  ready,
  output logic                  write_dropped,
  output logic                  array_we,
  output logic [ADDR_WIDTH-1:0] array_waddr,
  output logic [DATA_WIDTH-1:0] array_wdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = ADDR_WIDTH'(ZERO_REGISTER);

  rf_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic                  dropped_q, dropped_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      index_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    dropped_d = dropped_q;
    case (state_q)
      CLEAR: begin
        index_d = index_q + 1'b1;
        if (index_q == LAST_INDEX) state_d = READY;
        if (write_enable) dropped_d = 1'b1;
      end
      READY: begin
        // A write coinciding with a clear request loses to the clear.
        if (clear_request) begin
          state_d = CLEAR;
          index_d = '0;
          if (write_enable) dropped_d = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    ready         = (state_q == READY);
    write_dropped = dropped_q;
    array_we      = 1'b0;
    array_waddr   = index_q;
    array_wdata   = '0;
    case (state_q)
      CLEAR: array_we = 1'b1;
      READY: begin
        if (!clear_request && write_enable && (write_address != ZERO_ADDR)) begin
          array_we    = 1'b1;
          array_waddr = write_address;
          array_wdata = write_value;
        end
      end
      default: array_we = 1'b0;
    endcase
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file: two combinational read ports, one write port,
// registered debug read. Define REGISTER_FILE_BYPASS_EN for write-through reads.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
  input logic              clock,
  input logic              reset,
  register_file_if.slave   rf
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REGISTER);
  localparam int NUM_PORTS = 3;

  logic                  ready;
  logic                  array_we;
  logic [ADDR_WIDTH-1:0] array_waddr;
  logic [DATA_WIDTH-1:0] array_wdata;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  logic [ADDR_WIDTH-1:0] rd_addr [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rd_data [NUM_PORTS];

  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  register_file_clear_sequencer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_clear_sequencer (
    .clock         (clock),
    .reset         (reset),
    .write_enable  (rf.register_file_write_enable),
    .write_address (rf.register_file_write_address),
    .write_value   (rf.register_file_write_value),
    .clear_request (rf.clear_request),
    .ready         (ready),
    .write_dropped (rf.write_dropped),
    .array_we      (array_we),
    .array_waddr   (array_waddr),
    .array_wdata   (array_wdata)
  );

  // Storage is deliberately not reset; the sequencer zeroes it instead.
  always_ff @(posedge clock) begin
    if (array_we) mem_q[array_waddr] <= array_wdata;
  end

  assign rd_addr[0] = rf.register_file_read_address_1;
  assign rd_addr[1] = rf.register_file_read_address_2;
  assign rd_addr[2] = rf.debug_address;

  // Port 2 is the debug path so it shares zero-register and bypass handling.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_read
`ifdef REGISTER_FILE_BYPASS_EN
    logic hit;
    assign hit = ready && array_we && (array_waddr == rd_addr[gi]);
    assign rd_data[gi] = (!ready || rd_addr[gi] == ZERO_ADDR) ? '0 :
                         hit ? rf.register_file_write_value : mem_q[rd_addr[gi]];
`else
    assign rd_data[gi] = (!ready || rd_addr[gi] == ZERO_ADDR) ? '0 : mem_q[rd_addr[gi]];
`endif
  end

  assign rf.register_file_read_value_1 = rd_data[0];
  assign rf.register_file_read_value_2 = rd_data[1];
  assign rf.ready                      = ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ack_q  <= 1'b0;
      data_q <= '0;
    end else begin
      ack_q  <= ack_d;
      data_q <= data_d;
    end
  end

  // Requiring ack_q low paces a held request to every other cycle.
  always_comb begin
    ack_d  = 1'b0;
    data_d = data_q;
    if (ready && rf.debug_request && !ack_q) begin
      ack_d  = 1'b1;
      data_d = rd_data[2];
    end
  end

  assign rf.debug_acknowledge = ack_q;
  assign rf.debug_data        = data_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expectations follow the
// bypass macro REGISTER_FILE_BYPASS_EN when it is defined.
module tb_register_file;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   cycles;
  logic nonzero_seen;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) rf_if ();

  register_file dut (
    .clock (clock),
    .reset (reset),
    .rf    (rf_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Counts edges until ready (bounded); optionally issues one write to
  // address 5 at cycle drop_at and watches read port 1 for nonzero data.
  task automatic wait_ready(input int drop_at, output int n);
    n = 0;
    nonzero_seen = 1'b0;
    while (rf_if.ready !== 1'b1 && n < 200) begin
      step();
      n++;
      rf_if.register_file_write_enable = (n == drop_at);
      rf_if.register_file_write_address = 6'd5;
      rf_if.register_file_write_value   = 32'h0000_1111;
      #1;
      if (rf_if.register_file_read_value_1 !== 32'h0) nonzero_seen = 1'b1;
    end
    rf_if.register_file_write_enable = 1'b0;
  endtask

  task automatic write_reg(input logic [5:0] a, input logic [31:0] v);
    rf_if.register_file_write_enable  = 1'b1;
    rf_if.register_file_write_address = a;
    rf_if.register_file_write_value   = v;
    step();
    rf_if.register_file_write_enable  = 1'b0;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    rf_if.register_file_read_address_1 = 6'd5;
    rf_if.register_file_read_address_2 = 6'd0;
    rf_if.register_file_write_address  = 6'd0;
    rf_if.register_file_write_value    = 32'h0;
    rf_if.register_file_write_enable   = 1'b0;
    rf_if.clear_request                = 1'b0;
    rf_if.debug_request                = 1'b0;
    rf_if.debug_address                = 6'd0;
    repeat (3) step();
    check_value("rst_ready", {31'b0, rf_if.ready}, 32'd0);
    check_value("rst_dropped", {31'b0, rf_if.write_dropped}, 32'd0);
    check_value("rst_ack", {31'b0, rf_if.debug_acknowledge}, 32'd0);
    check_value("rst_dbg_data", rf_if.debug_data, 32'h0);

    reset = 1'b1;
    wait_ready(0, cycles);
    check_value("clear_cycles", cycles, 32'd64);
    check_value("clear_rd5_zero", {31'b0, nonzero_seen}, 32'd0);

    rf_if.debug_request = 1'b1;
    rf_if.debug_address = 6'd63;
    step();
    rf_if.debug_request = 1'b0;
    check_value("dbg63_ack", {31'b0, rf_if.debug_acknowledge}, 32'd1);
    check_value("dbg63_data", rf_if.debug_data, 32'h0);
    step();
    check_value("dbg63_ack_drop", {31'b0, rf_if.debug_acknowledge}, 32'd0);

    rf_if.register_file_read_address_1 = 6'd7;
    write_reg(6'd7, 32'h1234_5678);
    check_value("wr7_rd1", rf_if.register_file_read_value_1, 32'h1234_5678);

    rf_if.register_file_read_address_1 = 6'd0;
    write_reg(6'd0, 32'hFFFF_FFFF);
    check_value("wr0_rd1", rf_if.register_file_read_value_1, 32'h0);
    check_value("wr0_dropped", {31'b0, rf_if.write_dropped}, 32'd0);

    rf_if.register_file_read_address_2 = 6'd3;
    rf_if.register_file_write_enable   = 1'b1;
    rf_if.register_file_write_address  = 6'd3;
    rf_if.register_file_write_value    = 32'hA5A5_A5A5;
    #1;
`ifdef REGISTER_FILE_BYPASS_EN
    check_value("bypass_rd2", rf_if.register_file_read_value_2, 32'hA5A5_A5A5);
`else
    check_value("bypass_rd2", rf_if.register_file_read_value_2, 32'h0);
`endif
    step();
    rf_if.register_file_write_enable = 1'b0;
    #1;
    check_value("after_wr3_rd2", rf_if.register_file_read_value_2, 32'hA5A5_A5A5);

    rf_if.register_file_read_address_1 = 6'd9;
    write_reg(6'd9, 32'h0000_DEAD);
    check_value("wr9_rd1", rf_if.register_file_read_value_1, 32'h0000_DEAD);
    rf_if.clear_request = 1'b1;
    step();
    rf_if.clear_request = 1'b0;
    #1;
    check_value("clrreq_ready", {31'b0, rf_if.ready}, 32'd0);
    check_value("clrreq_rd1", rf_if.register_file_read_value_1, 32'h0);
    rf_if.register_file_read_address_1 = 6'd5;
    wait_ready(10, cycles);
    check_value("clrreq_cycles", cycles, 32'd64);
    check_value("drop_flag", {31'b0, rf_if.write_dropped}, 32'd1);
    check_value("drop_rd5", rf_if.register_file_read_value_1, 32'h0);
    rf_if.register_file_read_address_1 = 6'd9;
    #1;
    check_value("clr_rd9", rf_if.register_file_read_value_1, 32'h0);
    rf_if.register_file_read_address_2 = 6'd7;
    #1;
    check_value("clr_rd7", rf_if.register_file_read_value_2, 32'h0);

    rf_if.clear_request = 1'b1;
    step();
    rf_if.clear_request = 1'b0;
    repeat (20) step();
    reset = 1'b0;
    #1;
    check_value("midclr_dropped", {31'b0, rf_if.write_dropped}, 32'd0);
    step();
    reset = 1'b1;
    wait_ready(0, cycles);
    check_value("midclr_cycles", cycles, 32'd64);

    write_reg(6'd9, 32'h0000_BEEF);
    rf_if.debug_request = 1'b1;
    rf_if.debug_address = 6'd9;
    for (int i = 0; i < 6; i++) begin
      step();
      check_value($sformatf("dbg_hold_ack%0d", i), {31'b0, rf_if.debug_acknowledge},
                  (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) check_value($sformatf("dbg_hold_data%0d", i), rf_if.debug_data, 32'h0000_BEEF);
    end

    step();
    check_value("dbg_pre_rst_ack", {31'b0, rf_if.debug_acknowledge}, 32'd1);
    reset = 1'b0;
    #1;
    check_value("dbg_rst_ack", {31'b0, rf_if.debug_acknowledge}, 32'd0);
    check_value("dbg_rst_data", rf_if.debug_data, 32'h0);
    rf_if.debug_request = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
